mem1p_rw_arbiter: RTL

MEM1P_RW_ARBITER -- requirements
Module: mem1p_rw_arbiter

---
 rtl/axi_mem_pkg.sv | 12 +
 rtl/arb_valid_pipe.sv | 26 ++
 rtl/mem1p_rw_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the single-port memory read/write arbiter.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_WR = 2'd1,
        OWN_RD = 2'd2
    } arb_state_t;

    localparam int C_BURST_CNT_W = 8;

endpackage

// File: rtl/arb_valid_pipe.sv
// Read-valid shift register: delays each read grant by the memory read latency.
module arb_valid_pipe #(
    parameter int G_DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    output logic o_valid
);

    logic [G_DEPTH-1:0] r_pipe;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_valid;
            for (int i = 1; i < G_DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_valid = r_pipe[G_DEPTH-1];

endmodule

// File: rtl/mem1p_rw_arbiter.sv
// Arbitrates one write and one read requester onto a single-port memory,
// bounding consecutive grants to one side while the other side waits.
//
// state  | meaning
// IDLE   | no grant issued last cycle; write wins a tie
// OWN_WR | write was granted last cycle
// OWN_RD | read was granted last cycle
module mem1p_rw_arbiter
    import axi_mem_pkg::*;
#(
    parameter int G_DATAWIDTH  = 32,
    parameter int G_ADDRWIDTH  = 10,
    parameter int G_WEWIDTH    = ((G_DATAWIDTH - 1) / 8) + 1,
    parameter int G_MAX_BURST  = 4,
    parameter int G_RD_LATENCY = 1
) (
    input  logic                   s_aclk,
    input  logic                   s_aresetn,
    input  logic                   wr_req,
    input  logic [G_ADDRWIDTH-1:0] wr_addr,
    input  logic [G_DATAWIDTH-1:0] wr_data,
    input  logic [G_WEWIDTH-1:0]   wr_strb,
    output logic                   wr_gnt,
    input  logic                   rd_req,
    input  logic [G_ADDRWIDTH-1:0] rd_addr,
    output logic                   rd_gnt,
    output logic [G_DATAWIDTH-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   mem_en,
    output logic [G_WEWIDTH-1:0]   mem_we,
    output logic [G_ADDRWIDTH-1:0] mem_addr,
    output logic [G_DATAWIDTH-1:0] mem_din,
    input  logic [G_DATAWIDTH-1:0] mem_dout
);

    localparam logic [C_BURST_CNT_W-1:0] C_MAX = C_BURST_CNT_W'(G_MAX_BURST);

    arb_state_t               r_state;
    arb_state_t               w_state_nxt;
    logic [C_BURST_CNT_W-1:0] r_cnt;
    logic [C_BURST_CNT_W-1:0] w_cnt_nxt;
    logic                     w_cnt_sat;
    logic                     w_wr_sel;
    logic                     w_rd_sel;
    logic                     w_wr_gnt;
    logic                     w_rd_gnt;

    assign w_cnt_sat = (r_cnt >= C_MAX);

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_wr_sel    = 1'b0;
        w_rd_sel    = 1'b0;
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;

        if (wr_req && !rd_req) begin
            w_wr_sel = 1'b1;
        end else if (rd_req && !wr_req) begin
            w_rd_sel = 1'b1;
        end else if (wr_req && rd_req) begin
            case (r_state)
                OWN_WR: begin
                    w_wr_sel = !w_cnt_sat;
                    w_rd_sel = w_cnt_sat;
                end
                OWN_RD: begin
                    w_rd_sel = !w_cnt_sat;
                    w_wr_sel = w_cnt_sat;
                end
                default: w_wr_sel = 1'b1;
            endcase
        end

        // Repeat grant to the owner advances the burst; any other grant restarts it.
        if (w_wr_sel) begin
            w_state_nxt = OWN_WR;
            if (r_state == OWN_WR) begin
                w_cnt_nxt = w_cnt_sat ? r_cnt : r_cnt + 1'b1;
            end else begin
                w_cnt_nxt = C_BURST_CNT_W'(1);
            end
        end else if (w_rd_sel) begin
            w_state_nxt = OWN_RD;
            if (r_state == OWN_RD) begin
                w_cnt_nxt = w_cnt_sat ? r_cnt : r_cnt + 1'b1;
            end else begin
                w_cnt_nxt = C_BURST_CNT_W'(1);
            end
        end
    end

    // Grants are combinational, so they must also be masked while reset is held.
    assign w_wr_gnt = w_wr_sel & s_aresetn;
    assign w_rd_gnt = w_rd_sel & s_aresetn;

    assign wr_gnt   = w_wr_gnt;
    assign rd_gnt   = w_rd_gnt;
    assign mem_en   = w_wr_gnt | w_rd_gnt;
    assign mem_we   = w_wr_gnt ? wr_strb : '0;
    assign mem_addr = w_wr_gnt ? wr_addr : rd_addr;
    assign mem_din  = wr_data;
    assign rd_data  = mem_dout;

    arb_valid_pipe #(
        .G_DEPTH (G_RD_LATENCY)
    ) u_valid_pipe (
        .i_clk   (s_aclk),
        .i_rst_n (s_aresetn),
        .i_valid (w_rd_gnt),
        .o_valid (rd_valid)
    );

endmodule
